// File: rtl/mod_updown_counter.sv
// Parametrised up/down modulo counter with load, prescaler and cascade tc.
// Optional saturation instead of wrap-around: define COUNTER_SATURATE_EN.
module mod_updown_counter #(
  parameter int unsigned     WIDTH    = 4,
  parameter longint unsigned MODULUS  = 16,
  parameter int unsigned     PRESCALE = 1
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             enable,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] q,
  output logic             tc_out,
  output logic             wrap,
  output logic             load_err
);

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 1);
  localparam logic [7:0]       PMAX = 8'(PRESCALE - 1);

  logic [WIDTH-1:0] q_q, q_d;
  logic [7:0]       pre_q, pre_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;

  logic step_pending;
  logic at_max;
  logic at_zero;
  logic at_terminal;
  logic in_range;

  // Terminal detection and load range check
  always_comb begin
    step_pending = (pre_q == PMAX);
    at_max       = (q_q == MAXV);
    at_zero      = (q_q == '0);
    at_terminal  = up_down ? at_max : at_zero;
    in_range     = (64'(load_value) < MODULUS);
  end

  // Cascade output: same-cycle so the next stage can step on this edge
  assign tc_out = enable & ~load & step_pending & at_terminal;

  // Next-state: load over enable over hold
  always_comb begin
    q_d    = q_q;
    pre_d  = pre_q;
    wrap_d = 1'b0;
    err_d  = 1'b0;
    if (load) begin
      pre_d = '0;
      if (in_range) begin
        q_d = load_value;
      end else begin
        q_d   = MAXV;
        err_d = 1'b1;
      end
    end else if (enable) begin
      if (!step_pending) begin
        pre_d = pre_q + 8'd1;
      end else begin
        pre_d = '0;
        if (up_down) begin
          if (at_max) begin
`ifdef COUNTER_SATURATE_EN
            q_d = MAXV;
`else
            q_d    = '0;
            wrap_d = 1'b1;
`endif
          end else begin
            q_d = q_q + 1'b1;
`ifdef COUNTER_SATURATE_EN
            wrap_d = (q_d == MAXV);
`endif
          end
        end else begin
          if (at_zero) begin
`ifdef COUNTER_SATURATE_EN
            q_d = '0;
`else
            q_d    = MAXV;
            wrap_d = 1'b1;
`endif
          end else begin
            q_d = q_q - 1'b1;
`ifdef COUNTER_SATURATE_EN
            wrap_d = (q_d == '0);
`endif
          end
        end
      end
    end
  end

  // State registers, cleared asynchronously
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      q_q    <= '0;
      pre_q  <= '0;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      q_q    <= q_d;
      pre_q  <= pre_d;
      wrap_q <= wrap_d;
      err_q  <= err_d;
    end
  end

  assign q        = q_q;
  assign wrap     = wrap_q;
  assign load_err = err_q;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Scoreboard bench for mod_updown_counter: single MODULUS=10/PRESCALE=3
// instance plus a two-digit decimal cascade of MODULUS=10/PRESCALE=1.
module tb_mod_updown_counter;

  localparam int M = 10;
  localparam int P = 3;

  logic       clk = 1'b0;
  logic       clear = 1'b0;
  logic       enable = 1'b0;
  logic       up_down = 1'b1;
  logic       load = 1'b0;
  logic [3:0] load_value = '0;
  logic [3:0] q;
  logic       tc_out, wrap, load_err;

  logic       c_en = 1'b0;
  logic       c_ud = 1'b1;
  logic [3:0] lo_q, hi_q;
  logic       lo_tc, hi_tc, lo_wrap, hi_wrap, lo_err, hi_err;

  int checks = 0;
  int failures = 0;

  // expected tc, expected {q,wrap,load_err}, expected {value,both_wrap}
  bit       tc_exp_q[$];
  bit [5:0] st_exp_q[$];
  bit [7:0] cas_exp_q[$];

  // reference state
  int cnt = 0;
  int pc = 0;
  int v = 0;

  always #5 clk = ~clk;

  mod_updown_counter #(.WIDTH(4), .MODULUS(M), .PRESCALE(P)) dut (
    .clk(clk), .clear(clear), .enable(enable), .up_down(up_down),
    .load(load), .load_value(load_value), .q(q), .tc_out(tc_out),
    .wrap(wrap), .load_err(load_err)
  );

  mod_updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1)) lo (
    .clk(clk), .clear(clear), .enable(c_en), .up_down(c_ud),
    .load(1'b0), .load_value(4'd0), .q(lo_q), .tc_out(lo_tc),
    .wrap(lo_wrap), .load_err(lo_err)
  );

  mod_updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1)) hi (
    .clk(clk), .clear(clear), .enable(lo_tc), .up_down(c_ud),
    .load(1'b0), .load_value(4'd0), .q(hi_q), .tc_out(hi_tc),
    .wrap(hi_wrap), .load_err(hi_err)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus plus the reference model's prediction
  task automatic drive(input bit en, input bit ud, input bit ld,
                       input int lv, input bit cen, input bit cud);
    bit tc, wr, er, wb;
    @(negedge clk);
    enable = en;
    up_down = ud;
    load = ld;
    load_value = lv[3:0];
    c_en = cen;
    c_ud = cud;
    #1;
    tc = en && !ld && pc == P - 1 && (ud ? cnt == M - 1 : cnt == 0);
    wr = 0;
    er = 0;
    if (ld) begin
      pc = 0;
      if (lv < M) cnt = lv;
      else begin
        cnt = M - 1;
        er = 1;
      end
    end else if (en) begin
      if (pc != P - 1) pc++;
      else begin
        pc = 0;
`ifdef COUNTER_SATURATE_EN
        if (ud && cnt < M - 1) begin
          cnt++;
          wr = (cnt == M - 1);
        end else if (!ud && cnt > 0) begin
          cnt--;
          wr = (cnt == 0);
        end
`else
        if (ud) begin
          wr = (cnt == M - 1);
          cnt = (cnt + 1) % M;
        end else begin
          wr = (cnt == 0);
          cnt = (cnt + M - 1) % M;
        end
`endif
      end
    end
    wb = 0;
    if (cen) begin
      if (cud) begin
        wb = (v == 99);
        v = (v + 1) % 100;
      end else begin
        wb = (v == 0);
        v = (v + 99) % 100;
      end
    end
    tc_exp_q.push_back(tc);
    st_exp_q.push_back({cnt[3:0], wr, er});
    cas_exp_q.push_back({v[6:0], wb});
  endtask

  task automatic rand_cycle();
    drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
          $urandom_range(0, 7) == 0, $urandom_range(0, 15),
          $urandom_range(0, 3) != 0, $urandom_range(0, 6) != 0);
  endtask

  // Monitor: tc mid-cycle, registered outputs just after each edge
  initial begin
    bit       et;
    bit [5:0] es;
    bit [7:0] ec;
    forever begin
      @(negedge clk);
      #2;
      if (tc_exp_q.size() > 0) begin
        et = tc_exp_q.pop_front();
        chk("tc_out", int'(tc_out), int'(et));
      end
      @(posedge clk);
      #1;
      if (st_exp_q.size() > 0) begin
        es = st_exp_q.pop_front();
        chk("q", int'(q), int'(es[5:2]));
        chk("wrap", int'(wrap), int'(es[1]));
        chk("load_err", int'(load_err), int'(es[0]));
        if (wrap && load_err) chk("wrap_and_err", 1, 0);
      end
`ifndef COUNTER_SATURATE_EN
      if (cas_exp_q.size() > 0) begin
        ec = cas_exp_q.pop_front();
        chk("cascade_value", int'(hi_q) * 10 + int'(lo_q), int'(ec[7:1]));
        chk("cascade_both_wrap", int'(lo_wrap & hi_wrap), int'(ec[0]));
      end
`else
      if (cas_exp_q.size() > 0) ec = cas_exp_q.pop_front();
`endif
    end
  end

  initial begin
    #2;
    chk("reset_q", int'(q), 0);
    chk("reset_wrap", int'(wrap), 0);
    chk("reset_err", int'(load_err), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    clear = 1'b1;

    // down across zero with prescale 3 and a 2-cycle enable gap
    drive(1, 0, 1, 1, 0, 1);
    repeat (3) drive(1, 0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0, 1);
    repeat (2) drive(0, 0, 0, 0, 0, 1);
    repeat (2) drive(1, 0, 0, 0, 0, 1);
    // up wrap from 0, cascade counting up past 99
    drive(1, 1, 1, 0, 1, 1);
    repeat (40) drive(1, 1, 0, 0, 1, 1);
    repeat (70) drive(0, 1, 0, 0, 1, 1);
    // clamp then in-range load, enable held high
    drive(1, 1, 1, 12, 0, 1);
    drive(1, 1, 1, 4, 0, 1);
    drive(1, 1, 1, 9, 0, 1);
    drive(1, 1, 1, 15, 0, 1);

    repeat (400) rand_cycle();

    // asynchronous clear between edges with q at 7
    drive(0, 1, 1, 7, 0, 1);
    @(negedge clk);
    enable = 0;
    load = 0;
    c_en = 0;
    #3;
    clear = 1'b0;
    #1;
    chk("async_clear_q", int'(q), 0);
    chk("async_clear_wrap", int'(wrap), 0);
    chk("async_clear_err", int'(load_err), 0);
    chk("async_clear_cascade", int'(hi_q) * 10 + int'(lo_q), 0);
    cnt = 0;
    pc = 0;
    v = 0;
    enable = 1;
    @(posedge clk);
    #1;
    chk("clear_hold_q", int'(q), 0);
    @(negedge clk);
    enable = 0;
    clear = 1'b1;

    repeat (400) rand_cycle();
    drive(0, 1, 0, 0, 0, 1);

    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_drained", st_exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mod_updown_counter.md
Name: mod_updown_counter

Overview:
- Parametrised synchronous binary counter; successor to the team's fixed 4-bit enable/clear ripple-enable counter.
- Adds:
  - configurable width and modulus
  - up/down direction
  - parallel load
  - integer prescaler
  - cascade-ready terminal-count output
- Used as the general counter/timer primitive.
- Multiple instances chain through tc_out -> enable to form wider or multi-digit (e.g. BCD) counters.

Parameters:
- WIDTH, 4, counter register width in bits (1..32).
- MODULUS, 16, count range 0..MODULUS-1; must satisfy 2 <= MODULUS <= 2^WIDTH.
- PRESCALE, 1, enabled clock cycles per count step (1..256); 1 = step every enabled cycle.

Ports:
- clk  input  1  rising-edge clock.
- clear  input  1  asynchronous active-low reset.
- enable  input  1  count enable; also cascade input from a lower stage's tc_out.
- up_down  input  1  1 = count up, 0 = count down; sampled each cycle.
- load  input  1  synchronous parallel load strobe.
- load_value  input  WIDTH  value loaded when load=1.
- q  output  WIDTH  current count, registered.
- tc_out  output  1  terminal count; combinational.
- wrap  output  1  one-cycle registered pulse on each modulus wrap.
- load_err  output  1  one-cycle registered pulse when an out-of-range load is clamped.

Behaviour:
- Reset (clear=0, asynchronous, independent of clk):
  - q=0, prescaler count=0, wrap=0, load_err=0.
  - Reset holds while clear=0; the first edge after release behaves normally.
- Priority per rising edge: clear > load > enable > hold.
- Load (load=1):
  - q <= load_value when load_value < MODULUS.
  - Otherwise q <= MODULUS-1 and load_err=1 for that cycle.
  - Prescaler resets to 0; wrap=0.
  - Load is honoured regardless of enable.
- Prescaler:
  - 8-bit internal count, advances only when enable=1 and load=0.
  - A "step" occurs on an enabled cycle where the prescaler equals PRESCALE-1; the prescaler then returns to 0.
  - With PRESCALE=1, every enabled cycle is a step.
  - enable=0 freezes the prescaler; it does not clear it.
- Step, up (up_down=1): q <= q+1; if q == MODULUS-1 then q <= 0 and wrap=1 next cycle.
- Step, down (up_down=0): q <= q-1; if q == 0 then q <= MODULUS-1 and wrap=1 next cycle.
- Arithmetic: modulo MODULUS, WIDTH bits. No intermediate value ever exceeds MODULUS-1.
- tc_out:
  - = enable & step_pending & at_terminal.
  - at_terminal = (q == MODULUS-1) when counting up, (q == 0) when counting down.
  - step_pending = prescaler at PRESCALE-1.
  - Combinational, so the next stage's enable sees it in the same cycle. This mirrors the AND-chain cascade of the current counter.
  - Forced to 0 while load=1.
- Direction change: takes effect on the same edge; no extra latency, no glitch in q.
- wrap and load_err: high for exactly one cycle; never high together.
- Latency: q updates on the edge after the controlling inputs are sampled.

Optional Feature:
- Macro: COUNTER_SATURATE_EN.
- Defined:
  - Counter saturates instead of wrapping: holds at MODULUS-1 when stepping up, holds at 0 when stepping down.
  - wrap becomes a one-cycle pulse on the first step into saturation only; further steps at the limit give no pulse.
  - tc_out is still asserted at the limit.
- Undefined: modulo wrap-around as described above. This is the default.

Test Plan:
- Reset mid-count: WIDTH=4, MODULUS=16, PRESCALE=1, count to q=7, assert clear asynchronously between edges -> q=0 immediately; wrap=0, load_err=0.
- Up wrap: MODULUS=10, PRESCALE=1, enable=1, up_down=1 from 0 -> q sequence 0..9,0.
  - tc_out=1 only while q=9.
  - wrap=1 in the cycle q shows 0.
- Down wrap with prescale: MODULUS=10, PRESCALE=3, up_down=0, start q=1 -> q steps every 3rd enabled cycle: 1,0,9.
  - tc_out=1 on the third cycle at q=0.
  - Deassert enable for 2 cycles mid-prescale -> step is delayed by exactly 2 cycles.
- Load priority and clamp: MODULUS=10, enable=1, load=1, load_value=12 -> q=9, load_err pulses one cycle, tc_out=0 during load.
  - load_value=4 -> q=4, load_err=0.
- Cascade: two instances, MODULUS=10 each, low.tc_out -> high.enable, count 0 up to 99 -> high.q increments exactly when low wraps.
  - Combined value goes 99 -> 00 with both wrap pulses on the same cycle.
- Saturate (COUNTER_SATURATE_EN defined): MODULUS=16, up from 14 for 4 steps -> q=14,15,15,15.
  - Single wrap pulse on reaching 15.
  - Reverse direction -> q=14 next step.
